// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
// regfile_pkg
// Shared types and constants for the register-file write arbiter slice.
//   DATA_W / ADDR_W / NUM_REGS : geometry of the 16 x 32 register file
//   REQ_MEM / REQ_ALU          : requester ids (also the rr_ptr encoding)
//   entry_t                    : one holding-buffer entry {full, rd, data}
//   entry_hits()               : "entry holds a write to register idx"
// Optional feature macro used elsewhere in the slice: REGFILE_BYPASS_EN
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    localparam logic REQ_MEM = 1'b0;
    localparam logic REQ_ALU = 1'b1;

    typedef struct packed {
        logic              full;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    // True when the entry is occupied and targets register idx.
    function automatic logic entry_hits(input entry_t e, input logic [ADDR_W-1:0] idx);
        return e.full && (e.rd == idx);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// regfile_write_arbiter_if
// Write-back request bundle for the two requesters (ALU results, MEM loads).
//   alu_valid/alu_ready/alu_rd/alu_data : ALU write request handshake
//   mem_valid/mem_ready/mem_rd/mem_data : load write request handshake
// Modports:
//   master : the execute/memory stages (drive valid/rd/data, see ready)
//   slave  : the arbiter (sees valid/rd/data, drives ready)
// ============================================================================
interface regfile_write_arbiter_if import regfile_pkg::*;;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready
    );

endinterface

// File: rtl/regfile_write_arbiter_hold_entry.sv
// ============================================================================
// rf_hold_entry
// One-entry holding buffer for a single write-back requester.
//   clock    : system clock
//   reset_n  : synchronous active-low reset (empties the entry)
//   valid_i  : requester offers a write this cycle
//   clear_i  : the arbiter grants this entry this cycle
//   rd_i     : destination register of the offered write
//   data_i   : data of the offered write
//   ready_o  : entry can accept this cycle (empty, or draining now)
//   load_o   : transfer happens at the coming edge (valid && ready)
//   entry_o  : registered entry contents {full, rd, data}
// ============================================================================
module rf_hold_entry
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              load_o,
    output entry_t            entry_o
);

    entry_t entry_q;
    entry_t entry_d;

    // Ready is held low throughout reset so nothing is accepted and then lost.
    assign ready_o = reset_n && (!entry_q.full || clear_i);
    assign load_o  = valid_i && ready_o;
    assign entry_o = entry_q;

    // Next-state: a load wins over a clear, giving back-to-back throughput.
    always_comb begin
        entry_d = entry_q;
        if (load_o) begin
            entry_d.full = 1'b1;
            entry_d.rd   = rd_i;
            entry_d.data = data_i;
        end else if (clear_i) begin
            entry_d.full = 1'b0;
        end else begin
            entry_d = entry_q;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// regfile_write_arbiter
// Shares the register file's single write port between ALU write-back and
// memory-load write-back. Each requester owns a one-entry holding buffer;
// buffered writes are granted round-robin, except that two writes to the same
// register always drain oldest first. Pending flags expose buffered writes to
// the hazard/stall logic.
//
// Ports:
//   clock, reset_n         : clock, synchronous active-low reset
//   req (slave modport)    : ALU and MEM valid/ready/rd/data handshakes
//   rf_RW/rf_EnW/rf_BusW   : register file write port
//   rf_EN                  : register file global enable (1 after reset)
//   query_ra/query_rb      : read indices mirrored from the register file
//   ra_pending/rb_pending  : a buffered write targets query_ra / query_rb
//   rf_BusA/rf_BusB        : register file read data
//   fwd_A/fwd_B            : operands to the datapath
//
// Optional feature: define REGFILE_BYPASS_EN to forward buffered data onto
// fwd_A/fwd_B (youngest matching entry wins). Without it the operands are a
// pass-through of rf_BusA/rf_BusB.
// Widths come from regfile_pkg (DATA_W = 32, ADDR_W = 4).
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    regfile_write_arbiter_if.slave    req,
    output logic [ADDR_W-1:0]         rf_RW,
    output logic                      rf_EnW,
    output logic [DATA_W-1:0]         rf_BusW,
    output logic                      rf_EN,
    input  logic [ADDR_W-1:0]         query_ra,
    input  logic [ADDR_W-1:0]         query_rb,
    output logic                      ra_pending,
    output logic                      rb_pending,
    input  logic [DATA_W-1:0]         rf_BusA,
    input  logic [DATA_W-1:0]         rf_BusB,
    output logic [DATA_W-1:0]         fwd_A,
    output logic [DATA_W-1:0]         fwd_B
);

    entry_t mem_entry_s;
    entry_t alu_entry_s;
    logic   mem_ready_s;
    logic   alu_ready_s;
    logic   mem_load_s;
    logic   alu_load_s;
    logic   grant_mem_s;
    logic   grant_alu_s;
    logic   both_full_s;
    logic   same_rd_s;

    logic   rr_ptr_q;
    logic   rr_ptr_d;
    logic   mem_older_q;
    logic   mem_older_d;
    logic   rf_en_q;

    rf_hold_entry u_mem_entry (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (req.mem_valid),
        .clear_i (grant_mem_s),
        .rd_i    (req.mem_rd),
        .data_i  (req.mem_data),
        .ready_o (mem_ready_s),
        .load_o  (mem_load_s),
        .entry_o (mem_entry_s)
    );

    rf_hold_entry u_alu_entry (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (req.alu_valid),
        .clear_i (grant_alu_s),
        .rd_i    (req.alu_rd),
        .data_i  (req.alu_data),
        .ready_o (alu_ready_s),
        .load_o  (alu_load_s),
        .entry_o (alu_entry_s)
    );

    assign req.mem_ready = mem_ready_s;
    assign req.alu_ready = alu_ready_s;

    assign both_full_s = mem_entry_s.full && alu_entry_s.full;
    assign same_rd_s   = (mem_entry_s.rd == alu_entry_s.rd);

    // Grant selection. No grant during reset: held writes are dropped, not
    // committed, so the register file never sees a write while reset_n=0.
    always_comb begin
        grant_mem_s = 1'b0;
        grant_alu_s = 1'b0;
        if (!reset_n) begin
            grant_mem_s = 1'b0;
            grant_alu_s = 1'b0;
        end else if (both_full_s) begin
            if (same_rd_s) begin
                // Same target: must drain in program order or the older value
                // would overwrite the newer one.
                if (mem_older_q) begin
                    grant_mem_s = 1'b1;
                end else begin
                    grant_alu_s = 1'b1;
                end
            end else if (rr_ptr_q == REQ_MEM) begin
                grant_mem_s = 1'b1;
            end else begin
                grant_alu_s = 1'b1;
            end
        end else if (mem_entry_s.full) begin
            grant_mem_s = 1'b1;
        end else if (alu_entry_s.full) begin
            grant_alu_s = 1'b1;
        end else begin
            grant_mem_s = 1'b0;
            grant_alu_s = 1'b0;
        end
    end

    // Round-robin pointer and relative-age next state.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mem_older_d = mem_older_q;

        // Only a contested grant moves the pointer, toward the loser.
        if (both_full_s && grant_mem_s) begin
            rr_ptr_d = REQ_ALU;
        end else if (both_full_s && grant_alu_s) begin
            rr_ptr_d = REQ_MEM;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // Age only matters while both entries are full, so it is updated when
        // one entry is (re)loaded while the other keeps its write.
        if (mem_load_s && alu_load_s) begin
            mem_older_d = 1'b1;
        end else if (mem_load_s && alu_entry_s.full && !grant_alu_s) begin
            mem_older_d = 1'b0;
        end else if (alu_load_s && mem_entry_s.full && !grant_mem_s) begin
            mem_older_d = 1'b1;
        end else begin
            mem_older_d = mem_older_q;
        end
    end

    // Arbitration state and register file enable flop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q    <= REQ_MEM;
            mem_older_q <= 1'b0;
            rf_en_q     <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_older_q <= mem_older_d;
            rf_en_q     <= 1'b1;
        end
    end

    assign rf_EN = rf_en_q;

    // Write port mux; idle port drives zeros.
    always_comb begin
        rf_EnW  = 1'b0;
        rf_RW   = {ADDR_W{1'b0}};
        rf_BusW = {DATA_W{1'b0}};
        case ({grant_alu_s, grant_mem_s})
            2'b01: begin
                rf_EnW  = 1'b1;
                rf_RW   = mem_entry_s.rd;
                rf_BusW = mem_entry_s.data;
            end
            2'b10: begin
                rf_EnW  = 1'b1;
                rf_RW   = alu_entry_s.rd;
                rf_BusW = alu_entry_s.data;
            end
            default: begin
                rf_EnW  = 1'b0;
                rf_RW   = {ADDR_W{1'b0}};
                rf_BusW = {DATA_W{1'b0}};
            end
        endcase
    end

    assign ra_pending = entry_hits(mem_entry_s, query_ra) || entry_hits(alu_entry_s, query_ra);
    assign rb_pending = entry_hits(mem_entry_s, query_rb) || entry_hits(alu_entry_s, query_rb);

`ifdef REGFILE_BYPASS_EN
    // Youngest buffered write to idx, or the register file value if none.
    function automatic logic [DATA_W-1:0] bypass_sel(
        input entry_t            mem_e,
        input entry_t            alu_e,
        input logic              mem_is_older,
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] rf_val
    );
        logic hit_mem;
        logic hit_alu;
        hit_mem = entry_hits(mem_e, idx);
        hit_alu = entry_hits(alu_e, idx);
        if (hit_mem && hit_alu) begin
            return mem_is_older ? alu_e.data : mem_e.data;
        end else if (hit_mem) begin
            return mem_e.data;
        end else if (hit_alu) begin
            return alu_e.data;
        end else begin
            return rf_val;
        end
    endfunction

    assign fwd_A = bypass_sel(mem_entry_s, alu_entry_s, mem_older_q, query_ra, rf_BusA);
    assign fwd_B = bypass_sel(mem_entry_s, alu_entry_s, mem_older_q, query_rb, rf_BusB);
`else
    assign fwd_A = rf_BusA;
    assign fwd_B = rf_BusB;
`endif

endmodule
